spi_regfile: RTL and testbench



---
 rtl/spi_regfile_pkg.sv | 18 +
 rtl/spi_sync_edge.sv | 29 ++
 rtl/spi_regfile.sv | 233 +++++++++++++++++++++++
 tb/tb_spi_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Header length: one R/W bit followed by the address field.
    function automatic int unsigned hdr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a delay flop for rise/fall strobes.
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~s3_q;
    assign fall_o  = ~s2_q & s3_q;

endmodule

// File: rtl/spi_regfile.sv
// Mode-0 SPI register file with burst auto-increment, write strobes and framing errors.
// Read-back on CIPO is built only when SPI_REGFILE_READBACK_EN is defined.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 5,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         COPI,
    output logic                         CIPO,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o,
    output logic                         frame_err_o,
    output logic                         busy_o
);

    localparam int unsigned HDR_W   = hdr_w(ADDR_W);
    localparam int unsigned CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    // Holds the bits preceding the one being sampled; the current bit comes straight from COPI.
    localparam int unsigned SR_W    = CNT_MAX - 1;

    logic ncs_lvl, ncs_rise, ncs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;

    spi_sync_edge u_sync_ncs (
        .clk     (clk),
        .rst     (rst),
        .din_i   (nCS),
        .level_o (ncs_lvl),
        .rise_o  (ncs_rise),
        .fall_o  (ncs_fall)
    );

    spi_sync_edge u_sync_sclk (
        .clk     (clk),
        .rst     (rst),
        .din_i   (SCLK),
        .level_o (sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge u_sync_copi (
        .clk     (clk),
        .rst     (rst),
        .din_i   (COPI),
        .level_o (copi_lvl),
        .rise_o  (copi_rise),
        .fall_o  (copi_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{ncs_lvl, sclk_lvl, copi_rise, copi_fall};

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]       in_sr_q, in_sr_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  word_seen_q, word_seen_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  frame_err_q, frame_err_d;

    logic [HDR_W-1:0]      hdr_word;
    logic [DATA_W-1:0]     data_word;
    logic                  hdr_last, data_last;

    assign hdr_word  = {in_sr_q[HDR_W-2:0], copi_lvl};
    assign data_word = {in_sr_q[DATA_W-2:0], copi_lvl};
    assign hdr_last  = (bit_cnt_q == CNT_W'(HDR_W - 1));
    assign data_last = (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        in_sr_d     = in_sr_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        word_seen_d = word_seen_q;
        regs_d      = regs_q;
        wr_pulse_d  = '0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ncs_fall) begin
                    state_d     = StHdr;
                    bit_cnt_d   = '0;
                    word_seen_d = 1'b0;
                end
            end
            StHdr: begin
                if (ncs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    in_sr_d = SR_W'({in_sr_q, copi_lvl});
                    if (hdr_last) begin
                        rw_d      = hdr_word[HDR_W-1];
                        addr_d    = hdr_word[ADDR_W-1:0];
                        bit_cnt_d = '0;
                        state_d   = StData;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (ncs_rise) begin
                    state_d     = StIdle;
                    frame_err_d = (bit_cnt_q != '0) || !word_seen_q;
                end else if (sclk_rise) begin
                    in_sr_d = SR_W'({in_sr_q, copi_lvl});
                    if (data_last) begin
                        bit_cnt_d   = '0;
                        word_seen_d = 1'b1;
                        addr_d      = addr_q + 1'b1;
                        // Addresses past the last register simply match no entry.
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (rw_q == RW_WRITE && addr_q == ADDR_W'(k)) begin
                                regs_d[k]     = data_word;
                                wr_pulse_d[k] = 1'b1;
                            end
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            in_sr_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            word_seen_q <= 1'b0;
            wr_pulse_q  <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sr_q     <= in_sr_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            word_seen_q <= word_seen_d;
            wr_pulse_q  <= wr_pulse_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) regs_o[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign wr_pulse_o  = wr_pulse_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != StIdle);

`ifdef SPI_REGFILE_READBACK_EN
    logic [DATA_W-1:0] out_sr_q, out_sr_d;
    logic              cipo_q, cipo_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] hdr_rd_word, next_rd_word;
    logic              rd_active;

    assign rd_active = (state_q == StData) && (rw_q == RW_READ);

    always_comb begin
        hdr_rd_word  = '0;
        next_rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (hdr_word[ADDR_W-1:0] == ADDR_W'(k)) hdr_rd_word = regs_q[k];
            if (addr_q + 1'b1 == ADDR_W'(k)) next_rd_word = regs_q[k];
        end
    end

    always_comb begin
        out_sr_d = out_sr_q;
        cipo_d   = cipo_q;
        oe_d     = oe_q;
        if (ncs_rise) begin
            cipo_d = 1'b0;
            oe_d   = 1'b0;
        end else if (state_q == StHdr && sclk_rise && hdr_last) begin
            out_sr_d = hdr_rd_word;
        end else if (rd_active && sclk_fall) begin
            cipo_d   = out_sr_q[DATA_W-1];
            oe_d     = 1'b1;
            out_sr_d = out_sr_q << 1;
        end else if (rd_active && sclk_rise && data_last) begin
            out_sr_d = next_rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_sr_q <= '0;
            cipo_q   <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            out_sr_q <= out_sr_d;
            cipo_q   <= cipo_d;
            oe_q     <= oe_d;
        end
    end

    assign CIPO    = cipo_q;
    assign cipo_oe = oe_q;
`else
    logic unused_rd;
    assign unused_rd = sclk_fall;
    assign CIPO      = 1'b0;
    assign cipo_oe   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: frame-level model of registers, strobes and CIPO data.
module tb_spi_regfile;

    localparam int NR   = 5;
    localparam int DW   = 8;
    localparam int AW   = 7;
    localparam int HW   = AW + 1;
    localparam int HALF = 6;
`ifdef SPI_REGFILE_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nCS = 1'b1;
    logic SCLK = 1'b0;
    logic COPI = 1'b0;
    logic CIPO, cipo_oe, frame_err_o, busy_o;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]    wr_pulse_o;

    spi_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .nCS         (nCS),
        .SCLK        (SCLK),
        .COPI        (COPI),
        .CIPO        (CIPO),
        .cipo_oe     (cipo_oe),
        .regs_o      (regs_o),
        .wr_pulse_o  (wr_pulse_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mdl [NR];
    int            pulse_cnt [NR];
    int            err_cnt;
    bit            settled = 1'b0;
    logic          cap_c [64];
    logic          cap_o [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = mdl[k];
        return f;
    endfunction

    // Tally strobes every cycle; single-clk strobes make these equal committed-word counts.
    always @(negedge clk) begin
        for (int k = 0; k < NR; k++) if (wr_pulse_o[k] === 1'b1) pulse_cnt[k]++;
        if (frame_err_o === 1'b1) err_cnt++;
    end

    // Between frames the outputs must sit exactly at the model state.
    always @(negedge clk) begin
        if (settled) begin
            total++;
            if (regs_o !== model_flat() || busy_o !== 1'b0 || CIPO !== 1'b0 ||
                cipo_oe !== 1'b0 || wr_pulse_o !== '0 || frame_err_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_state: regs=%0h busy=%b cipo=%b oe=%b wp=%b fe=%b expected regs=%0h",
                         regs_o, busy_o, CIPO, cipo_oe, wr_pulse_o, frame_err_o, model_flat());
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, output logic c, output logic o);
        COPI = b;
        wait_clk(HALF);
        c = CIPO;
        o = cipo_oe;
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
        err_cnt = 0;
    endtask

    // Apply a whole frame to the model and compare everything the DUT did during it.
    task automatic model_frame(input logic [63:0] bits, input int n);
        int   exp_p [NR];
        int   exp_err, nw, rem, a, ad, wd, bp;
        logic rw;
        logic exp_o, exp_c;
        logic [DW-1:0] val, w;
        for (int k = 0; k < NR; k++) exp_p[k] = 0;
        rw = 1'b0; a = 0; nw = 0;
        if (n < HW) begin
            exp_err = 1;
        end else begin
            rw      = bits[n-1];
            a       = int'(bits[n-2 -: AW]);
            nw      = (n - HW) / DW;
            rem     = (n - HW) % DW;
            exp_err = (rem != 0 || nw == 0) ? 1 : 0;
        end
        for (int j = 0; j < n; j++) begin
            exp_o = RB && n >= HW && !rw && j >= HW;
            exp_c = 1'b0;
            if (exp_o) begin
                wd    = (j - HW) / DW;
                bp    = DW - 1 - ((j - HW) % DW);
                ad    = (a + wd) % (1 << AW);
                val   = (ad < NR) ? mdl[ad] : '0;
                exp_c = val[bp];
            end
            check($sformatf("cipo_oe bit%0d", j), 64'(cap_o[j]), 64'(exp_o));
            check($sformatf("cipo bit%0d", j), 64'(cap_c[j]), 64'(exp_c));
        end
        if (n >= HW && rw) begin
            for (int i = 0; i < nw; i++) begin
                w  = bits[n-1-HW-DW*i -: DW];
                ad = (a + i) % (1 << AW);
                if (ad < NR) begin
                    mdl[ad] = w;
                    exp_p[ad]++;
                end
            end
        end
        for (int k = 0; k < NR; k++) check($sformatf("wr_pulse_cnt[%0d]", k), 64'(pulse_cnt[k]), 64'(exp_p[k]));
        check("frame_err_cnt", 64'(err_cnt), 64'(exp_err));
    endtask

    task automatic run_frame(input logic [63:0] bits, input int n);
        logic c, o;
        settled = 1'b0;
        clear_counts();
        nCS = 1'b0;
        wait_clk(HALF);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i], c, o);
            cap_c[n-1-i] = c;
            cap_o[n-1-i] = o;
        end
        wait_clk(HALF);
        nCS = 1'b1;
        wait_clk(12);
        model_frame(bits, n);
        settled = 1'b1;
        wait_clk(4);
    endtask

    function automatic logic [DW-1:0] captured_word(input int first);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[DW-1-i] = cap_c[first+i];
        return r;
    endfunction

    initial begin
        logic c, o;
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        clear_counts();
        wait_clk(5);
        check("reset regs", 64'(regs_o), 64'(0));
        check("reset busy", 64'(busy_o), 64'(0));
        check("reset cipo", 64'(CIPO), 64'(0));
        rst = 1'b0;
        wait_clk(10);
        settled = 1'b1;
        wait_clk(4);

        run_frame(64'h81A5, 16);
        check("single reg1", 64'(regs_o[15:8]), 64'hA5);
        check("single reg0", 64'(regs_o[7:0]), 64'h00);

        run_frame(64'h8311_2233, 32);
        check("burst reg3", 64'(regs_o[31:24]), 64'h11);
        check("burst reg4", 64'(regs_o[39:32]), 64'h22);

        run_frame(64'h825A, 16);
        run_frame(64'h0200, 16);
        check("read reg2", 64'(captured_word(8)), RB ? 64'h5A : 64'h00);

        run_frame(64'h01_0000, 24);
        check("burst read reg1", 64'(captured_word(8)), RB ? 64'hA5 : 64'h00);
        check("burst read reg2", 64'(captured_word(16)), RB ? 64'h5A : 64'h00);

        run_frame(64'h1000, 16);

        run_frame(64'h84F, 12);
        check("abort err count", 64'(err_cnt), 64'(1));
        run_frame(64'h81, 8);
        run_frame(64'hB, 4);
        run_frame(64'h84C3, 16);
        check("after abort reg4", 64'(regs_o[39:32]), 64'hC3);

        run_frame(64'hFF_0102, 24);
        check("wrap reg0", 64'(regs_o[7:0]), 64'h02);

        // Reset with nCS held low: the rest of the frame must be ignored.
        settled = 1'b0;
        clear_counts();
        nCS = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 5; i++) send_bit(i[0], c, o);
        wait_clk(2);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        for (int k = 0; k < NR; k++) mdl[k] = '0;
        for (int i = 0; i < 11; i++) send_bit(1'b1, c, o);
        check("post-reset busy", 64'(busy_o), 64'(0));
        wait_clk(HALF);
        nCS = 1'b1;
        wait_clk(12);
        check("post-reset err", 64'(err_cnt), 64'(0));
        for (int k = 0; k < NR; k++) check($sformatf("post-reset pulses[%0d]", k), 64'(pulse_cnt[k]), 64'(0));
        settled = 1'b1;
        wait_clk(4);

        run_frame(64'h803C, 16);
        check("post-reset reg0", 64'(regs_o[7:0]), 64'h3C);
        check("post-reset reg1", 64'(regs_o[15:8]), 64'h00);

        settled = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
